burst_send_ctrl: RTL and testbench
==================================

Name: burst_send_ctrl

Overview:
Parametrised multi-channel send controller for the median-filter output path.
- Accepts a burst request carrying a buffer size.
- Writes one header word to each of N_SIDE sideband FIFOs atomically (all in the same cycle).
- Streams send_buff_size pixel writes to the pixel FIFO, honouring full back-pressure.
- Adds over the previous generation: a configurable sideband channel count, request acknowledge, size validation, back-to-back bursts and a done pulse.

Parameters:
BUFF_SIZE, 32, maximum burst length in pixels.
BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1, width of the size and count buses.
N_SIDE, 4, number of sideband control FIFOs written once per burst.

Ports:
clk  in  1  Single clock; all logic is on its rising edge.
rst_n  in  1  Reset, synchronous and active-low.
send_buff_size  in  BUFF_SIZE_BIT  Requested burst length; sampled only on acceptance.
send_req  in  1  Burst request level.
send_ack  out  1  Combinational; high in the cycle a request is consumed (accepted or rejected).
px_full  in  1  Pixel FIFO full.
side_full  in  N_SIDE  Per-channel sideband FIFO full.
px_wr  out  1  Pixel FIFO write strobe.
side_wr  out  N_SIDE  Sideband write strobes.
sending  out  1  High in HDR and DATA states.
send_count  out  BUFF_SIZE_BIT  Index of the next pixel to write.
send_done  out  1  Registered one-cycle pulse after the final pixel write.
err_size  out  1  Registered one-cycle pulse after a rejected request.

Behaviour:
- Reset (rst_n==0 at a clock edge):
  - state=IDLE; size_samp, send_count, send_done and err_size all go to 0.
  - send_ack, px_wr and side_wr are forced to 0 while rst_n==0, regardless of send_req.
  - Reset asserted mid-burst abandons the burst; no further writes occur.
- Size validation: valid means 1 <= send_buff_size <= BUFF_SIZE.
- IDLE:
  - send_req with a valid size: send_ack=1, size_samp<=send_buff_size, next state HDR.
  - send_req with an invalid size: send_ack=1, err_size pulses next cycle, state stays IDLE.
- HDR (header write):
  - When side_full==0: side_wr set to all ones for one cycle, next state DATA.
  - When any side_full bit is 1: side_wr=0 and state holds. Partial header writes are never allowed.
  - px_wr=0 throughout HDR.
- DATA:
  - px_wr = ~px_full.
  - send_count increments on each px_wr and holds while px_full=1.
  - Last beat is defined as px_wr & (send_count==size_samp-1). On the last beat:
    - send_count<=0.
    - send_done pulses the next cycle.
    - If send_req is high with a valid size: send_ack=1, size is resampled, next state HDR. There is no idle bubble, so the header follows the last pixel by exactly one cycle.
    - If send_req is high with an invalid size: send_ack=1, err_size pulses, next state IDLE.
    - If send_req is low: next state IDLE.
  - send_req is ignored during HDR and during non-last DATA cycles; the requester holds it until send_ack.
- Latency:
  - Request acceptance to first side_wr: 1 cycle (with no sideband back-pressure).
  - side_wr to first px_wr: 1 cycle.
  - A size-N burst with no back-pressure occupies N+1 cycles of sending.
- Width rules:
  - Comparisons are done at BUFF_SIZE_BIT width.
  - size_samp-1 is never evaluated for size 0, because zero sizes are rejected.
  - BUFF_SIZE itself is representable since BUFF_SIZE_BIT carries one extra bit.

Decomposition:
- Shared package (median_send_pkg) holds:
  - the state encodings IDLE, HDR and DATA (2 bits);
  - a SIZE_OK helper constant/function.
- One sub-module, send_beat_counter, is parametrised on width. It provides:
  - enable, synchronous clear and count outputs;
  - a last flag computed against size_samp.
- The FSM and sampling register stay in the top module.

Test Plan:
- Single burst, size 4, no back-pressure: send_ack in cycle 0; side_wr=4'b1111 in cycle 1; px_wr in cycles 2-5 with send_count 0,1,2,3; send_done in cycle 6; sending low from cycle 6.
- Sideband back-pressure, size 2, side_full=4'b0100 for 3 cycles: side_wr stays 0 throughout the stall, then a single all-ones write; no px_wr occurs before it.
- Pixel back-pressure, size 8, px_full toggled every other DATA cycle: exactly 8 px_wr strobes; send_count holds on stalls; send_done follows the eighth write.
- Back-to-back bursts, sizes 3 then 5, send_req held high: second send_ack coincides with the third px_wr; side_wr follows on the next cycle; total of 8 px_wr and 2 send_done pulses.
- Invalid sizes 0 and 33 (BUFF_SIZE=32): send_ack and err_size pulse each time; no side_wr or px_wr; state remains IDLE. Size 32 is accepted and completes 32 writes.
- rst_n asserted low during the third pixel write of a size-10 burst: at the next edge all strobes are 0, send_count=0 and sending=0; a fresh size-2 request afterwards completes normally.

Source files
------------

// File: rtl/median_send_pkg.sv
// Shared state encoding and size validation for the median-filter send path.
package median_send_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } send_state_e;

  // Valid burst sizes are 1..max_size; callers zero-extend to 32 bits.
  function automatic logic size_ok(input logic [31:0] size, input logic [31:0] max_size);
    return (size != 32'd0) && (size <= max_size);
  endfunction

endpackage

// File: rtl/send_beat_counter.sv
// Pixel beat counter: counts enabled beats, flags the final beat of a burst.
module send_beat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] size_samp,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q, count_d;

  // size_samp is never zero while en can be high, so size_samp-1 cannot wrap.
  assign last  = en && (count_q == (size_samp - ONE));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/burst_send_ctrl.sv
// Burst send controller: atomic sideband header write, then a back-pressured
// pixel stream, with back-to-back request acceptance on the final beat.
module burst_send_ctrl
  import median_send_pkg::*;
#(
  parameter int BUFF_SIZE     = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter int N_SIDE        = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BUFF_SIZE_BIT-1:0] send_buff_size,
  input  logic                     send_req,
  output logic                     send_ack,
  input  logic                     px_full,
  input  logic [N_SIDE-1:0]        side_full,
  output logic                     px_wr,
  output logic [N_SIDE-1:0]        side_wr,
  output logic                     sending,
  output logic [BUFF_SIZE_BIT-1:0] send_count,
  output logic                     send_done,
  output logic                     err_size
);

  send_state_e              state_q, state_d;
  logic [BUFF_SIZE_BIT-1:0] size_samp_q, size_samp_d;
  logic                     send_done_q, send_done_d;
  logic                     err_size_q, err_size_d;
  logic                     size_valid;
  logic                     beat_last;

  assign size_valid = size_ok(32'(send_buff_size), 32'(BUFF_SIZE));

  // Kept outside the FSM block so the counter's last flag does not loop back into it.
  assign px_wr = rst_n && (state_q == DATA) && !px_full;

  send_beat_counter #(.W(BUFF_SIZE_BIT)) u_beat_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (px_wr),
    .clr       (beat_last),
    .size_samp (size_samp_q),
    .count     (send_count),
    .last      (beat_last)
  );

  always_comb begin
    state_d     = state_q;
    size_samp_d = size_samp_q;
    send_done_d = 1'b0;
    err_size_d  = 1'b0;
    send_ack    = 1'b0;
    side_wr     = '0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (send_req) begin
            send_ack = 1'b1;
            if (size_valid) begin
              size_samp_d = send_buff_size;
              state_d     = HDR;
            end else begin
              err_size_d = 1'b1;
            end
          end
        end
        HDR: begin
          // All sideband channels are written together or not at all.
          if (side_full == '0) begin
            side_wr = '1;
            state_d = DATA;
          end
        end
        DATA: begin
          if (beat_last) begin
            send_done_d = 1'b1;
            state_d     = IDLE;
            if (send_req) begin
              send_ack = 1'b1;
              if (size_valid) begin
                size_samp_d = send_buff_size;
                state_d     = HDR;
              end else begin
                err_size_d = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      size_samp_q <= '0;
      send_done_q <= 1'b0;
      err_size_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_samp_q <= size_samp_d;
      send_done_q <= send_done_d;
      err_size_q  <= err_size_d;
    end
  end

  assign sending   = (state_q != IDLE);
  assign send_done = send_done_q;
  assign err_size  = err_size_q;

endmodule

// File: tb/tb_burst_send_ctrl.sv
// Self-checking bench: directed scenarios then random traffic, compared each
// cycle against a transaction-level model (pending header, pixels remaining).
module tb_burst_send_ctrl;

  localparam int BS  = 32;
  localparam int BSB = 6;
  localparam int NS  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [BSB-1:0] send_buff_size;
  logic           send_req;
  logic           send_ack;
  logic           px_full;
  logic [NS-1:0]  side_full;
  logic           px_wr;
  logic [NS-1:0]  side_wr;
  logic           sending;
  logic [BSB-1:0] send_count;
  logic           send_done;
  logic           err_size;

  burst_send_ctrl #(.BUFF_SIZE(BS), .BUFF_SIZE_BIT(BSB), .N_SIDE(NS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .send_buff_size (send_buff_size),
    .send_req       (send_req),
    .send_ack       (send_ack),
    .px_full        (px_full),
    .side_full      (side_full),
    .px_wr          (px_wr),
    .side_wr        (side_wr),
    .sending        (sending),
    .send_count     (send_count),
    .send_done      (send_done),
    .err_size       (err_size)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_hdr;
  int m_left, m_size, m_idx;
  bit m_done, m_err;
  bit m_last_ack;

  int n_tests = 0, n_fail = 0;
  int px_cnt, side_cnt, done_cnt, err_cnt, ack_cnt;
  int px_mode = 0;
  bit tog = 1'b0;
  int stall = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    px_cnt = 0; side_cnt = 0; done_cnt = 0; err_cnt = 0; ack_cnt = 0;
  endtask

  // One clock: apply patterned inputs, check outputs, advance the model.
  task automatic cycle();
    bit valid, e_ack, e_px, nd, ne;
    logic [NS-1:0] e_side;
    if (px_mode == 1) begin tog = ~tog; px_full = tog; end
    if (stall > 0) begin side_full = 4'b0100; stall--; end
    else if (stall == 0) begin side_full = '0; stall = -1; end
    #1;
    valid  = (send_buff_size >= 1) && (int'(send_buff_size) <= BS);
    e_ack  = 1'b0;
    e_px   = 1'b0;
    e_side = '0;
    if (rst_n) begin
      if (m_hdr) e_side = (side_full == '0) ? '1 : '0;
      else if (m_left > 0) begin
        e_px  = !px_full;
        e_ack = e_px && (m_left == 1) && send_req;
      end else e_ack = send_req;
    end
    m_last_ack = e_ack;
    chk("send_ack",   32'(send_ack),   32'(e_ack));
    chk("px_wr",      32'(px_wr),      32'(e_px));
    chk("side_wr",    32'(side_wr),    32'(e_side));
    chk("sending",    32'(sending),    32'(m_hdr || m_left > 0));
    chk("send_count", 32'(send_count), 32'(m_idx));
    chk("send_done",  32'(send_done),  32'(m_done));
    chk("err_size",   32'(err_size),   32'(m_err));
    if (px_wr === 1'b1)     px_cnt++;
    if (side_wr != '0)      side_cnt++;
    if (send_done === 1'b1) done_cnt++;
    if (err_size === 1'b1)  err_cnt++;
    if (send_ack === 1'b1)  ack_cnt++;
    @(posedge clk);
    if (!rst_n) begin
      m_hdr = 0; m_left = 0; m_idx = 0; m_done = 0; m_err = 0;
    end else begin
      nd = 0; ne = 0;
      if (m_hdr) begin
        if (side_full == '0) begin m_hdr = 0; m_left = m_size; end
      end else if (m_left > 0) begin
        if (!px_full) begin
          m_idx++; m_left--;
          if (m_left == 0) begin
            m_idx = 0; nd = 1;
            if (send_req) begin
              if (valid) begin m_size = int'(send_buff_size); m_hdr = 1; end
              else ne = 1;
            end
          end
        end
      end else if (send_req) begin
        if (valid) begin m_size = int'(send_buff_size); m_hdr = 1; end
        else ne = 1;
      end
      m_done = nd; m_err = ne;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Hold a request until the model says it is consumed, then drop it.
  task automatic request(input int sz);
    bit got = 0;
    send_req = 1'b1;
    send_buff_size = BSB'(sz);
    for (int i = 0; i < 60 && !got; i++) begin
      cycle();
      got = m_last_ack;
    end
    chk("req_consumed", 32'(got), 32'd1);
    send_req = 1'b0;
  endtask

  initial begin
    int acks;
    rst_n = 1'b0; send_req = 1'b0; send_buff_size = '0;
    px_full = 1'b0; side_full = '0;
    m_hdr = 0; m_left = 0; m_size = 0; m_idx = 0; m_done = 0; m_err = 0;
    clr_counts();
    @(posedge clk); @(negedge clk);
    run(2);
    rst_n = 1'b1;
    cycle();

    // single burst, size 4
    clr_counts();
    request(4); run(7);
    chk("b4_px", 32'(px_cnt), 32'd4);
    chk("b4_side", 32'(side_cnt), 32'd1);
    chk("b4_done", 32'(done_cnt), 32'd1);

    // sideband stall during header
    clr_counts();
    stall = 4;
    request(2); run(8);
    chk("stall_px", 32'(px_cnt), 32'd2);
    chk("stall_side", 32'(side_cnt), 32'd1);

    // pixel back-pressure
    clr_counts();
    px_mode = 1;
    request(8); run(25);
    px_mode = 0; px_full = 1'b0;
    chk("bp_px", 32'(px_cnt), 32'd8);
    chk("bp_done", 32'(done_cnt), 32'd1);

    // back-to-back 3 then 5
    clr_counts();
    acks = 0;
    send_req = 1'b1; send_buff_size = 6'd3;
    for (int i = 0; i < 40 && acks < 2; i++) begin
      cycle();
      if (m_last_ack) begin
        acks++;
        send_buff_size = 6'd5;
        if (acks == 2) send_req = 1'b0;
      end
    end
    send_req = 1'b0;
    run(10);
    chk("b2b_px", 32'(px_cnt), 32'd8);
    chk("b2b_done", 32'(done_cnt), 32'd2);
    chk("b2b_side", 32'(side_cnt), 32'd2);
    chk("b2b_ack", 32'(ack_cnt), 32'd2);

    // invalid sizes, then the maximum size
    clr_counts();
    request(0); run(2);
    request(33); run(2);
    chk("inv_err", 32'(err_cnt), 32'd2);
    chk("inv_wr", 32'(px_cnt + side_cnt), 32'd0);
    chk("inv_ack", 32'(ack_cnt), 32'd2);
    clr_counts();
    request(32); run(40);
    chk("max_px", 32'(px_cnt), 32'd32);
    chk("max_done", 32'(done_cnt), 32'd1);

    // reset during the third pixel write of a size-10 burst
    clr_counts();
    request(10);
    for (int i = 0; i < 20 && px_cnt < 2; i++) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("rst_px", 32'(px_cnt), 32'd2);
    chk("rst_cnt", 32'(send_count), 32'd0);
    chk("rst_sending", 32'(sending), 32'd0);
    request(2); run(6);
    chk("post_rst_px", 32'(px_cnt), 32'd4);
    chk("post_rst_done", 32'(done_cnt), 32'd1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      send_req = ($urandom_range(0, 99) < 35);
      send_buff_size = ($urandom_range(0, 9) == 0) ? BSB'($urandom_range(0, 63))
                                                   : BSB'($urandom_range(1, 12));
      px_full   = ($urandom_range(0, 3) == 0);
      side_full = ($urandom_range(0, 6) == 0) ? NS'($urandom_range(1, 15)) : '0;
      rst_n     = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
